// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the single-port RAM and its arbitrated clients.
package ram_arbiter_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 32;

    typedef logic port_idx_t;

endpackage

// File: rtl/rsp_buffer.sv
// One-entry valid/ready holding register for read responses.
module rsp_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] ldata,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ldata;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port registered RAM.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int NPORT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPORT-1:0]        req_valid,
    output logic [NPORT-1:0]        req_ready,
    input  logic [NPORT-1:0]        req_we,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [NPORT*DATA_W-1:0] req_wdata,
    output logic [NPORT-1:0]        rsp_valid,
    input  logic [NPORT-1:0]        rsp_ready,
    output logic [NPORT*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    output logic                    ram_wen,
    input  logic [DATA_W-1:0]       ram_rdata
);

    port_idx_t          ptr;
    port_idx_t          gp;
    logic               pend_v;
    port_idx_t          pend_p;
    logic               any;
    logic [NPORT-1:0]   busy;
    logic [NPORT-1:0]   elig;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  last_addr;

    // A read is held back while its buffer is occupied at the capture edge:
    // either still full and not draining, or about to be filled by a tag.
    always_comb begin
        busy = '0;
        elig = '0;
        for (int p = 0; p < NPORT; p++) begin
            busy[p] = (rsp_valid[p] & ~rsp_ready[p])
                    | (pend_v & (pend_p == port_idx_t'(p)));
            elig[p] = rst_n & req_valid[p] & (req_we[p] | ~busy[p]);
        end
    end

    always_comb begin
        gp  = elig[ptr] ? ptr : ~ptr;
        any = |elig;
        req_ready = '0;
        if (any) req_ready[gp] = 1'b1;
        sel_addr  = req_addr[int'(gp)*ADDR_W +: ADDR_W];
        ram_addr  = any ? sel_addr : last_addr;
        ram_wdata = req_wdata[int'(gp)*DATA_W +: DATA_W];
        ram_wen   = any & req_we[gp];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            pend_v    <= 1'b0;
            pend_p    <= 1'b0;
            last_addr <= '0;
        end else begin
            pend_v <= any & ~req_we[gp];
            pend_p <= gp;
            if (any) begin
                ptr       <= ~gp;
                last_addr <= sel_addr;
            end
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_rsp
        rsp_buffer #(
            .DATA_W(DATA_W)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (pend_v & (pend_p == port_idx_t'(p))),
            .ldata (ram_rdata),
            .ready (rsp_ready[p]),
            .valid (rsp_valid[p]),
            .data  (rsp_rdata[p*DATA_W +: DATA_W])
        );
    end

endmodule
